// File: rtl/cpu_mobo_bus.sv
// Single-word bus stage between the CPU function FSM and the motherboard memory port.
// Define CPU_MOBO_BUS_TIMEOUT_EN to add the BUSY timeout counter and err reporting.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module cpu_mobo_bus #(
    parameter int WORD_WIDTH     = `WORD_WIDTH,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] mobo_ctrl,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_WIDTH-1:0] cpu_wdata,
    output logic [WORD_WIDTH-1:0] mobo_stat,
    output logic [WORD_WIDTH-1:0] cpu_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    // Handshake: mem_req is a level held from the cycle after the request is
    // sampled until the edge that sees the one-cycle mem_ack pulse; mem_ack
    // outside BUSY is ignored, and mem_rdata is only looked at with mem_ack.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic req;
    logic we;
    logic ack_hit;
    logic timeout_hit;
    logic busy_q;
    logic done_q;
    logic err_bit;

    assign req     = mobo_ctrl[0];
    assign we      = mobo_ctrl[1];
    assign ack_hit = (state == ST_BUSY) && mem_ack;

    logic unused_ctrl;
    assign unused_ctrl = ^mobo_ctrl[WORD_WIDTH-1:2];

`ifdef CPU_MOBO_BUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        err_q;

    // Ack in the limit cycle takes priority, so the limit only fires without one.
    assign timeout_hit = (state == ST_BUSY) && !mem_ack && (tmo_cnt == TMO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_IDLE) begin
            tmo_cnt <= '0;
        end else if ((state == ST_BUSY) && !mem_ack && (tmo_cnt != 16'hFFFF)) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end

    assign err_bit = err_q;
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
    assign err_bit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack || timeout_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Status flops are loaded from next_state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (next_state == ST_BUSY);
            done_q <= (next_state == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if ((state == ST_IDLE) && req) begin
            mem_we    <= we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata <= '0;
        end else if (ack_hit && !mem_we) begin
            cpu_rdata <= mem_rdata;
        end
    end

    assign mem_req   = busy_q;
    assign mobo_stat = {{(WORD_WIDTH-3){1'b0}}, err_bit, done_q, busy_q};

endmodule

// File: tb/tb_cpu_mobo_bus.sv
// Directed bench for cpu_mobo_bus: read, write, back-to-back, timeout,
// ack/timeout collision, spurious ack and mid-transaction reset.

module tb_cpu_mobo_bus;

    localparam int W = 32;
    localparam int A = 16;

    localparam logic [W-1:0] STAT_IDLE     = 32'h0;
    localparam logic [W-1:0] STAT_BUSY     = 32'h1;
    localparam logic [W-1:0] STAT_DONE_OK  = 32'h2;
    localparam logic [W-1:0] STAT_DONE_ERR = 32'h6;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] mobo_ctrl;
    logic [A-1:0] cpu_addr;
    logic [W-1:0] cpu_wdata;
    logic [W-1:0] mobo_stat;
    logic [W-1:0] cpu_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_ack;
    logic [W-1:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_rdata;
    int           busy_cnt;

    cpu_mobo_bus #(
        .WORD_WIDTH    (W),
        .ADDR_WIDTH    (A),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mobo_ctrl(mobo_ctrl),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .mobo_stat(mobo_stat),
        .cpu_rdata(cpu_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 64'd0, 64'd1);
        end else begin
            exp_rdata = exp_q.pop_front();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mobo_ctrl = '0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        exp_rdata = '0;
        tick();
        tick();
        check_eq("rst_stat", mobo_stat, STAT_IDLE);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_rdata", cpu_rdata, 0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_stat", mobo_stat, STAT_IDLE);

        // read 0x1234, ack one cycle after mem_req rises
        mobo_ctrl = 32'h1;
        cpu_addr  = 16'h1234;
        tick();
        mobo_ctrl = 32'h0;
        check_eq("rd_busy", mobo_stat, STAT_BUSY);
        check_eq("rd_req_c1", mem_req, 1);
        check_eq("rd_addr", mem_addr, 16'h1234);
        check_eq("rd_we", mem_we, 0);
        tick();
        check_eq("rd_req_c2", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        pop_exp();
        check_eq("rd_done", mobo_stat, STAT_DONE_OK);
        check_eq("rd_req_low", mem_req, 0);
        check_eq("rd_data", cpu_rdata, exp_rdata);
        tick();
        check_eq("rd_done_once", mobo_stat, STAT_IDLE);

        // write 0x00FF with req held across completion; inputs changed mid-BUSY
        mobo_ctrl = 32'h3;
        cpu_addr  = 16'h00FF;
        cpu_wdata = 32'hA5A5A5A5;
        tick();
        check_eq("wr_busy", mobo_stat, STAT_BUSY);
        check_eq("wr_we", mem_we, 1);
        check_eq("wr_addr", mem_addr, 16'h00FF);
        check_eq("wr_wdata", mem_wdata, 32'hA5A5A5A5);
        cpu_addr  = 16'hBEEF;
        cpu_wdata = 32'h12345678;
        tick();
        check_eq("wr_addr_hold", mem_addr, 16'h00FF);
        check_eq("wr_wdata_hold", mem_wdata, 32'hA5A5A5A5);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("wr_done", mobo_stat, STAT_DONE_OK);
        check_eq("wr_rdata_keep", cpu_rdata, exp_rdata);
        tick();
        check_eq("b2b_gap_req", mem_req, 0);
        check_eq("b2b_gap_stat", mobo_stat, STAT_IDLE);
        tick();
        mobo_ctrl = 32'h0;
        check_eq("b2b_req", mem_req, 1);
        check_eq("b2b_addr", mem_addr, 16'hBEEF);
        check_eq("b2b_wdata", mem_wdata, 32'h12345678);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("b2b_done", mobo_stat, STAT_DONE_OK);
        tick();

        // read 0x0040 with no ack
        mobo_ctrl = 32'h1;
        cpu_addr  = 16'h0040;
        tick();
        mobo_ctrl = 32'h0;
        tick();
        tick();
        tick();
        check_eq("tmo_c4_busy", mobo_stat, STAT_BUSY);
`ifdef CPU_MOBO_BUS_TIMEOUT_EN
        tick();
        check_eq("tmo_done_err", mobo_stat, STAT_DONE_ERR);
        check_eq("tmo_req_low", mem_req, 0);
        check_eq("tmo_rdata_keep", cpu_rdata, exp_rdata);
        tick();
        check_eq("tmo_after", mobo_stat, STAT_IDLE);
`else
        busy_cnt = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (mobo_stat == STAT_BUSY && mem_req) busy_cnt++;
        end
        check_eq("notmo_busy_cycles", busy_cnt, 110);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        exp_q.push_back(32'hCAFEF00D);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        pop_exp();
        check_eq("notmo_late_done", mobo_stat, STAT_DONE_OK);
        check_eq("notmo_late_data", cpu_rdata, exp_rdata);
        tick();
`endif

        // ack in the 4th BUSY cycle, coinciding with the timeout limit
        mobo_ctrl = 32'h1;
        cpu_addr  = 16'h0200;
        tick();
        mobo_ctrl = 32'h0;
        tick();
        tick();
        tick();
        check_eq("co_c4_busy", mobo_stat, STAT_BUSY);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BADF00D;
        exp_q.push_back(32'h0BADF00D);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        pop_exp();
        check_eq("co_done_ok", mobo_stat, STAT_DONE_OK);
        check_eq("co_data", cpu_rdata, exp_rdata);
        tick();

        // spurious ack while idle
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check_eq("spur_stat", mobo_stat, STAT_IDLE);
        check_eq("spur_req", mem_req, 0);
        check_eq("spur_rdata", cpu_rdata, exp_rdata);
        tick();
        check_eq("spur_stat2", mobo_stat, STAT_IDLE);

        // reset while a write to 0x0010 is outstanding
        mobo_ctrl = 32'h3;
        cpu_addr  = 16'h0010;
        cpu_wdata = 32'h55AA55AA;
        tick();
        mobo_ctrl = 32'h0;
        check_eq("mrst_busy", mobo_stat, STAT_BUSY);
        tick();
        rst_n = 1'b0;
        #1;
        exp_rdata = '0;
        check_eq("mrst_req", mem_req, 0);
        check_eq("mrst_stat", mobo_stat, STAT_IDLE);
        check_eq("mrst_we", mem_we, 0);
        check_eq("mrst_addr", mem_addr, 0);
        check_eq("mrst_wdata", mem_wdata, 0);
        check_eq("mrst_rdata", cpu_rdata, exp_rdata);
        tick();
        tick();
        check_eq("mrst_no_done", mobo_stat, STAT_IDLE);
        rst_n = 1'b1;
        tick();
        mobo_ctrl = 32'h1;
        cpu_addr  = 16'h0003;
        tick();
        mobo_ctrl = 32'h0;
        check_eq("post_rst_busy", mobo_stat, STAT_BUSY);
        check_eq("post_rst_addr", mem_addr, 16'h0003);
        mem_ack   = 1'b1;
        mem_rdata = 32'h13572468;
        exp_q.push_back(32'h13572468);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        pop_exp();
        check_eq("post_rst_done", mobo_stat, STAT_DONE_OK);
        check_eq("post_rst_data", cpu_rdata, exp_rdata);
        tick();
        check_eq("post_rst_idle", mobo_stat, STAT_IDLE);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mobo_bus.md
# cpu_mobo_bus

Bus-side stage downstream of the CPU read/write function states. Accepts a single-word read or write request encoded on `mobo_ctrl`, runs a req/ack handshake with the motherboard memory port, and reports busy/done/error on `mobo_stat` so the CPU function state machine can advance or return. One transaction in flight at a time; no buffering beyond the latched request.

## Interface
- `WORD_WIDTH`, default `` `WORD_WIDTH`` (32): data and control word width.
- `ADDR_WIDTH`, default 16: memory address width.
- `TIMEOUT_CYCLES`, default 255: maximum BUSY cycles before abort. Valid range 1..65535.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mobo_ctrl`  in  WORD_WIDTH  bit0 `req` (level), bit1 `we` (1 = write). Other bits are ignored.
- `cpu_addr`  in  ADDR_WIDTH  transaction address.
- `cpu_wdata`  in  WORD_WIDTH  write data.
- `mobo_stat`  out  WORD_WIDTH  bit0 `busy`, bit1 `done` (one-cycle pulse), bit2 `err` (valid with `done`). Other bits are 0.
- `cpu_rdata`  out  WORD_WIDTH  read data, held until the next successful read.
- `mem_req`  out  1  memory request, level.
- `mem_we`  out  1  latched `we`.
- `mem_addr`  out  ADDR_WIDTH  latched address.
- `mem_wdata`  out  WORD_WIDTH  latched write data.
- `mem_ack`  in  1  memory completion, one-cycle pulse.
- `mem_rdata`  in  WORD_WIDTH  valid when `mem_ack`=1.

## Operation
- FSM states:
  - IDLE: `busy`=0, `mem_req`=0. When `req`=1 at an edge: latch `we`, `cpu_addr` and `cpu_wdata` into `mem_we`, `mem_addr` and `mem_wdata`; clear the timeout counter; go to BUSY.
  - BUSY: `busy`=1, `mem_req`=1, latched fields stable.
    - `mem_ack`=1: go to DONE with `err`=0. On a read, capture `mem_rdata` into `cpu_rdata`.
    - Otherwise the counter increments. When the counter reaches `TIMEOUT_CYCLES`-1 without an ack, go to DONE with `err`=1. `cpu_rdata` is unchanged.
  - DONE: `done`=1 for exactly one cycle, `busy`=0, `mem_req`=0, then go to IDLE unconditionally.
- Input sampling:
  - `req` is sampled only in IDLE. Changes to `req`, `cpu_addr` and `cpu_wdata` during BUSY or DONE are ignored.
  - If `req` is still high in IDLE after DONE, a new transaction starts (back-to-back operation is allowed).
  - `mem_ack` outside BUSY is ignored. It has no effect on `cpu_rdata` or the FSM.
- Simultaneous events:
  - `mem_ack` in the same cycle as the timeout limit: ack wins, `err`=0.
- Counter: 16 bits, saturating; no wrap-around observable.
- Reset (any state, including mid-transaction):
  - Returns to IDLE immediately.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_rdata`, `mobo_stat` and the counter all reset to 0.
  - An aborted transaction produces no `done` pulse.

## Timing
- Cycle 0: edge samples `req`=1 in IDLE. Cycle 1: `mem_req`=1, `busy`=1.
- `mem_ack` seen at the edge ending BUSY cycle k: `done` is high during cycle k+1; `cpu_rdata` is valid from cycle k+1.
- Minimum latency: `mem_ack` asserted in cycle 1 gives `done` in cycle 2 (request to done = 2 cycles).
- Timeout: `done`/`err` rise after exactly `TIMEOUT_CYCLES` BUSY cycles.
- Back-to-back: `done` in cycle n, IDLE in n+1, `mem_req` again in n+2. At least one `mem_req`-low cycle separates transactions.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `CPU_MOBO_BUS_TIMEOUT_EN` defined:
  - Timeout counter and `err` reporting are present, as described above.
- Not defined:
  - Counter logic is removed and BUSY waits indefinitely for `mem_ack`.
  - `mobo_stat` bit2 is constant 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset mid-BUSY (write to 0x0010 outstanding, `rst_n` pulsed low) -> all outputs 0 immediately; no `done`; next `req` starts cleanly.
- Read 0x1234, `mem_ack` one cycle after `mem_req` with `mem_rdata`=0xDEADBEEF -> `mem_req` lasts 2 cycles, `done`=1 and `err`=0 for one cycle, `cpu_rdata`=0xDEADBEEF.
- Write 0x00FF with data 0xA5A5A5A5, `req` held high across completion -> `mem_we`=1 with latched data; second transaction's `mem_req` rises 2 cycles after `done`; `cpu_rdata` unchanged.
- `TIMEOUT_CYCLES`=4, no ack, macro defined -> `done`=1 and `err`=1 after 4 BUSY cycles; `cpu_rdata` keeps its previous value.
  - Same stimulus, macro undefined -> stays BUSY for 100+ cycles, then a late ack gives `done` with `err`=0.
- Ack coincident with the timeout limit (`TIMEOUT_CYCLES`=4, ack in the 4th BUSY cycle) -> `err`=0 and data captured.
  - Spurious `mem_ack` in IDLE -> no state change and no `cpu_rdata` change.
- Change `cpu_addr` and `cpu_wdata` during BUSY -> `mem_addr` and `mem_wdata` remain at the latched values.
